machine_step_seq: RTL and testbench
===================================

Name: machine_step_seq

Overview:
Clocked, parametrised successor to the combinational machine step function. Holds the machine state register, a DEPTH-entry pending queue and a RUN/HALT mode. Consumes one tagged command per handshake and returns one tagged response per command through a registered output stage. Sits between the command decoder and the result/writeback stage of the Machine datapath.

Parameters:
DATA_W, 32, width of one pending entry and of cmd_data
DEPTH, 10, pending queue capacity in entries (>=2)
STATE_W, 32, width of the machine state accumulator; must be >= DATA_W
CNT_W, $clog2(DEPTH+1), width of occupancy count

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset; asynchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  block accepts command this cycle
cmd_op  in  2  00 STEP, 01 PUSH, 10 POP, 11 FLUSH
cmd_data  in  DATA_W  payload for PUSH; ignored otherwise
resp_valid  out  1  response register holds a response
resp_ready  in  1  downstream consumes response
resp_code  out  2  00 OK, 01 EMPTY, 10 FULL, 11 HALTED
resp_data  out  STATE_W  response payload
state_out  out  STATE_W  current machine state
count  out  CNT_W  pending occupancy
halted  out  1  1 when FSM is in HALT

Behaviour:
- Reset (async, any cycle, mid-transaction included): state_out=0, count=0, queue pointers=0, FSM=RUN, halted=0, resp_valid=0, resp_code=00, resp_data=0. An in-flight response is dropped.
- Accept = cmd_valid & cmd_ready. cmd_ready = !resp_valid | resp_ready (one-entry skid-free output register; back-to-back throughput 1/cycle when resp_ready=1).
- Latency: the response for a command accepted in cycle N is visible with resp_valid=1 in cycle N+1. resp_* are held stable while resp_valid & !resp_ready.
- RUN, STEP: if count==0 -> EMPTY, resp_data=state, FSM->HALT. Else pop head; state <= state + zero-extended head, mod 2^STATE_W (wrap, no flag); OK, resp_data=new state.
- RUN, PUSH: if count==DEPTH -> FULL, resp_data=state, queue unchanged, FSM->HALT. Else write at tail; OK, resp_data=count after push.
- RUN, POP: if empty -> EMPTY, FSM->HALT. Else discard head; OK, resp_data=zero-extended discarded value.
- FLUSH (RUN or HALT): count<=0, pointers reset, FSM->RUN; OK, resp_data=count before flush. State register is preserved.
- HALT, STEP/PUSH/POP: no queue or state change; code HALTED, resp_data=state.
- Pointers wrap modulo DEPTH; DEPTH is not required to be a power of two.
- Only one command per cycle is accepted, so there are no simultaneous push/pop cases. A FLUSH arriving while the response register is stalled is simply not accepted until cmd_ready.
- cmd_op/cmd_data are sampled only on accept.
- The count, state_out and halted outputs reflect registered values, updated in the same edge as the response register.

Decomposition:
- Package machine_pkg: op encodings (OP_STEP, OP_PUSH, OP_POP, OP_FLUSH), response codes (RSP_OK, RSP_EMPTY, RSP_FULL, RSP_HALTED), FSM encoding (ST_RUN, ST_HALT).
- One sub-module: machine_pending_q, a circular queue (DEPTH x DATA_W) with push, pop, clear, head, count, full and empty. The top level holds the FSM, the state accumulator and the response register.

Test Plan:
- Reset mid-response: PUSH 0x5, assert rst while resp_valid=1 -> next cycle resp_valid=0, count=0, state_out=0, halted=0.
- Accumulate: PUSH 3, PUSH 4, STEP, STEP with resp_ready=1 -> codes OK/OK/OK/OK; resp_data 1, 2, 3, 7; state_out=7; count=0.
- Wrap: STATE_W=32, preload state 0xFFFFFFFE via PUSH 0xFFFFFFFE + STEP, then PUSH 5 + STEP -> resp_data=0x00000003, code OK.
- Full/halt: DEPTH=10, push 10 entries (OK), 11th PUSH -> FULL, halted=1. Next STEP -> HALTED with state unchanged. FLUSH -> OK with resp_data=10, count=0, halted=0.
- Empty: on an empty queue, POP -> EMPTY and halted=1. The following PUSH 9 -> HALTED and count stays 0.
- Backpressure: resp_ready=0 for 3 cycles after PUSH 1 -> cmd_ready=0, resp held (OK, 1). A STEP held on cmd_valid is accepted on the cycle resp_ready=1, and its response (OK, state+1) appears the next cycle.

Source files
------------

// File: rtl/machine_pkg.sv
// Shared encodings for the sequential machine step block: command ops,
// response codes and the RUN/HALT mode.
package machine_pkg;

    typedef enum logic [1:0] {
        OP_STEP  = 2'b00,
        OP_PUSH  = 2'b01,
        OP_POP   = 2'b10,
        OP_FLUSH = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        RSP_OK     = 2'b00,
        RSP_EMPTY  = 2'b01,
        RSP_FULL   = 2'b10,
        RSP_HALTED = 2'b11
    } rsp_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fsm_e;

endpackage

// File: rtl/machine_pending_q.sv
// Circular pending queue of DEPTH entries; DEPTH need not be a power of two,
// so pointers wrap by explicit compare rather than by overflow.
module machine_pending_q
    import machine_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 10,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_head,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              w_doPush;
    logic              w_doPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_head   = r_mem[r_head];

    // Requests that would overflow or underflow are dropped here as a safety net.
    assign w_doPush = i_push & ~o_full;
    assign w_doPop  = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_tail <= nextPtr(r_tail);
            end
            if (w_doPop) begin
                r_head <= nextPtr(r_head);
            end
            if (w_doPush && !w_doPop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_doPop && !w_doPush) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush && !i_clear) begin
            r_mem[r_tail] <= i_data;
        end
    end

endmodule

// File: rtl/machine_step_seq.sv
// Clocked machine step: state accumulator, pending queue and RUN/HALT mode,
// one tagged response per accepted command through a registered output stage.
module machine_step_seq
    import machine_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 10,
    parameter int STATE_W = 32,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [DATA_W-1:0]  cmd_data,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [1:0]         resp_code,
    output logic [STATE_W-1:0] resp_data,
    output logic [STATE_W-1:0] state_out,
    output logic [CNT_W-1:0]   count,
    output logic               halted
);

    fsm_e               r_fsm;
    logic [STATE_W-1:0] r_acc;
    logic               r_respValid;
    rsp_e               r_respCode;
    logic [STATE_W-1:0] r_respData;

    op_e                w_op;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_clear;
    logic [DATA_W-1:0]  w_head;
    logic [CNT_W-1:0]   w_count;
    logic               w_full;
    logic               w_empty;
    logic [STATE_W-1:0] w_sum;

    assign w_op      = op_e'(cmd_op);
    assign cmd_ready = ~r_respValid | resp_ready;
    assign w_accept  = cmd_valid & cmd_ready;
    assign w_sum     = r_acc + STATE_W'(w_head);

    assign resp_valid = r_respValid;
    assign resp_code  = r_respCode;
    assign resp_data  = r_respData;
    assign state_out  = r_acc;
    assign count      = w_count;
    assign halted     = (r_fsm == ST_HALT);

    // Queue side effects only happen in RUN, except FLUSH which always clears.
    always_comb begin
        w_push  = 1'b0;
        w_pop   = 1'b0;
        w_clear = 1'b0;
        if (w_accept) begin
            if (w_op == OP_FLUSH) begin
                w_clear = 1'b1;
            end else if (r_fsm == ST_RUN) begin
                w_push = (w_op == OP_PUSH) & ~w_full;
                w_pop  = ((w_op == OP_STEP) | (w_op == OP_POP)) & ~w_empty;
            end
        end
    end

    machine_pending_q #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_pendingQ (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .i_data  (cmd_data),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm       <= ST_RUN;
            r_acc       <= '0;
            r_respValid <= 1'b0;
            r_respCode  <= RSP_OK;
            r_respData  <= '0;
        end else if (w_accept) begin
            r_respValid <= 1'b1;
            if (w_op == OP_FLUSH) begin
                r_fsm      <= ST_RUN;
                r_respCode <= RSP_OK;
                r_respData <= STATE_W'(w_count);
            end else if (r_fsm == ST_HALT) begin
                r_respCode <= RSP_HALTED;
                r_respData <= r_acc;
            end else if (w_op == OP_STEP) begin
                if (w_empty) begin
                    r_fsm      <= ST_HALT;
                    r_respCode <= RSP_EMPTY;
                    r_respData <= r_acc;
                end else begin
                    r_acc      <= w_sum;
                    r_respCode <= RSP_OK;
                    r_respData <= w_sum;
                end
            end else if (w_op == OP_PUSH) begin
                if (w_full) begin
                    r_fsm      <= ST_HALT;
                    r_respCode <= RSP_FULL;
                    r_respData <= r_acc;
                end else begin
                    r_respCode <= RSP_OK;
                    r_respData <= STATE_W'(w_count) + STATE_W'(1);
                end
            end else begin
                // POP reports the discarded head; an empty POP echoes the state.
                if (w_empty) begin
                    r_fsm      <= ST_HALT;
                    r_respCode <= RSP_EMPTY;
                    r_respData <= r_acc;
                end else begin
                    r_respCode <= RSP_OK;
                    r_respData <= STATE_W'(w_head);
                end
            end
        end else if (resp_ready) begin
            r_respValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_machine_step_seq.sv
// Self-checking bench for machine_step_seq: directed scenarios followed by
// random commands checked against a queue-based reference model.
module tb_machine_step_seq;

    localparam logic [1:0] C_STEP  = 2'b00;
    localparam logic [1:0] C_PUSH  = 2'b01;
    localparam logic [1:0] C_POP   = 2'b10;
    localparam logic [1:0] C_FLUSH = 2'b11;
    localparam logic [1:0] R_OK     = 2'b00;
    localparam logic [1:0] R_EMPTY  = 2'b01;
    localparam logic [1:0] R_FULL   = 2'b10;
    localparam logic [1:0] R_HALTED = 2'b11;
    localparam int QDEPTH = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_code;
    logic [31:0] resp_data;
    logic [31:0] state_out;
    logic [3:0]  count;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    // Reference model: a plain queue, an accumulator and a halt flag.
    logic [31:0] mq[$];
    logic [31:0] mState;
    bit          mHalt;
    logic [1:0]  eCode;
    logic [31:0] eData;
    bit          eDataKnown;

    machine_step_seq #(
        .DATA_W  (32),
        .DEPTH   (QDEPTH),
        .STATE_W (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_code  (resp_code),
        .resp_data  (resp_data),
        .state_out  (state_out),
        .count      (count),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mState = '0;
        mHalt  = 1'b0;
    endtask

    task automatic modelStep(input logic [1:0] op, input logic [31:0] data);
        eDataKnown = 1'b1;
        if (op == C_FLUSH) begin
            eCode = R_OK;
            eData = 32'(mq.size());
            mq.delete();
            mHalt = 1'b0;
        end else if (mHalt) begin
            eCode = R_HALTED;
            eData = mState;
        end else if (op == C_STEP) begin
            if (mq.size() == 0) begin
                eCode = R_EMPTY;
                eData = mState;
                mHalt = 1'b1;
            end else begin
                mState = mState + mq.pop_front();
                eCode  = R_OK;
                eData  = mState;
            end
        end else if (op == C_PUSH) begin
            if (mq.size() == QDEPTH) begin
                eCode = R_FULL;
                eData = mState;
                mHalt = 1'b1;
            end else begin
                mq.push_back(data);
                eCode = R_OK;
                eData = 32'(mq.size());
            end
        end else begin
            if (mq.size() == 0) begin
                eCode      = R_EMPTY;
                eData      = '0;
                eDataKnown = 1'b0;
                mHalt      = 1'b1;
            end else begin
                eCode = R_OK;
                eData = mq.pop_front();
            end
        end
    endtask

    task automatic checkVisible(input string tag);
        checkOutput({tag, "/state"}, state_out, mState);
        checkOutput({tag, "/count"}, 32'(count), 32'(mq.size()));
        checkOutput({tag, "/halted"}, 32'(halted), 32'(mHalt));
    endtask

    task automatic checkResponse(input string tag);
        checkOutput({tag, "/valid"}, 32'(resp_valid), 32'd1);
        checkOutput({tag, "/code"}, 32'(resp_code), 32'(eCode));
        if (eDataKnown) begin
            checkOutput({tag, "/data"}, resp_data, eData);
        end
        checkVisible(tag);
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] data, input string tag);
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_data   = data;
        resp_ready = 1'b1;
        #1;
        checkOutput({tag, "/ready"}, 32'(cmd_ready), 32'd1);
        modelStep(op, data);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        checkResponse(tag);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = C_STEP;
        cmd_data   = '0;
        resp_ready = 1'b1;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst/valid", 32'(resp_valid), 32'd0);
        checkOutput("rst/code", 32'(resp_code), 32'd0);
        checkOutput("rst/data", resp_data, 32'd0);
        checkVisible("rst");
        @(negedge clk);
        rst = 1'b0;

        // Reset while a response is pending drops it.
        applyStimulus(C_PUSH, 32'h5, "midrst_push");
        #2 rst = 1'b1;
        modelReset();
        #1;
        checkOutput("midrst/valid", 32'(resp_valid), 32'd0);
        checkVisible("midrst");
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(C_PUSH, 32'd3, "acc_push3");
        applyStimulus(C_PUSH, 32'd4, "acc_push4");
        applyStimulus(C_STEP, 32'd0, "acc_step1");
        applyStimulus(C_STEP, 32'd0, "acc_step2");
        checkOutput("acc/final_state", state_out, 32'd7);

        doReset();
        applyStimulus(C_PUSH, 32'hFFFF_FFFE, "wrap_push");
        applyStimulus(C_STEP, 32'd0, "wrap_step1");
        applyStimulus(C_PUSH, 32'd5, "wrap_push5");
        applyStimulus(C_STEP, 32'd0, "wrap_step2");
        checkOutput("wrap/result", resp_data, 32'h0000_0003);

        for (int i = 0; i < QDEPTH; i++) begin
            applyStimulus(C_PUSH, 32'(i + 1), "full_push");
        end
        applyStimulus(C_PUSH, 32'hAA, "full_over");
        checkOutput("full/code", 32'(resp_code), 32'(R_FULL));
        applyStimulus(C_STEP, 32'd0, "full_halted_step");
        applyStimulus(C_FLUSH, 32'd0, "full_flush");
        checkOutput("full/flush_data", resp_data, 32'd10);

        applyStimulus(C_POP, 32'd0, "empty_pop");
        applyStimulus(C_PUSH, 32'd9, "empty_halted_push");
        applyStimulus(C_FLUSH, 32'd0, "empty_flush");

        // Backpressure: response held while resp_ready is low, queued STEP waits.
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_op     = C_PUSH;
        cmd_data   = 32'd1;
        resp_ready = 1'b1;
        modelStep(C_PUSH, 32'd1);
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        cmd_op     = C_STEP;
        cmd_data   = 32'hDEAD;
        checkResponse("bp_push");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp/ready_low", 32'(cmd_ready), 32'd0);
            checkResponse("bp_hold");
        end
        @(negedge clk);
        resp_ready = 1'b1;
        #1;
        checkOutput("bp/ready_high", 32'(cmd_ready), 32'd1);
        modelStep(C_STEP, 32'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        checkResponse("bp_step");
        @(posedge clk);
        #1;
        checkOutput("bp/drain", 32'(resp_valid), 32'd0);

        doReset();
        for (int n = 0; n < 300; n++) begin
            int sel;
            logic [1:0] op;
            sel = int'($urandom_range(0, 19));
            if (sel < 8)       op = C_PUSH;
            else if (sel < 13) op = C_STEP;
            else if (sel < 18) op = C_POP;
            else               op = C_FLUSH;
            applyStimulus(op, $urandom, "rand");
        end
        @(posedge clk);
        #1;
        checkOutput("end/idle", 32'(resp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
